cpu_run_controller: RTL

Synthesisable run controller for the Harvard MIPS CPU. It sequences CPU reset and clock enable and counts executed cycles. It enforces a configurable timeout, flags simultaneous data read/write, and captures `register_v0` when the CPU drops `active`. It sits between a host/start source and `mips_cpu_harvard`, replacing bench-only timeout and assertion logic so the same checks run on FPGA and in simulation.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 24 ++
 rtl/cpu_run_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM states, result codes, counter width.
package run_ctrl_pkg;

    localparam int CYCLE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_HOLD,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } run_state_t;

    typedef enum logic [1:0] {
        STAT_OK        = 2'd0,
        STAT_TIMEOUT   = 2'd1,
        STAT_CONFLICT  = 2'd2,
        STAT_NO_ACTIVE = 2'd3
    } run_status_t;

endpackage

// File: rtl/sat_counter.sv
// Purpose: W-bit up counter with synchronous clear that sticks at all-ones.
// Latency: count visible the cycle after the enabled edge; clear wins over enable.
// Backpressure: none; en simply stalls the count.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Purpose: sequences CPU reset/clock-enable, counts RUN cycles, reports OK/TIMEOUT/CONFLICT/NO_ACTIVE (conflict check: RUN_CTRL_CONFLICT_CHECK_EN).
// Latency: cpu_reset rises 1 cycle after start; result/status valid the cycle done rises.
// Backpressure: start is ignored while busy; no other flow control.
module cpu_run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 15,
    parameter int unsigned RESET_HOLD_CYCLES = 1,
    parameter int          DATA_W            = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               cpu_reset,
    output logic               cpu_clk_enable,
    input  logic               cpu_active,
    input  logic               cpu_data_read,
    input  logic               cpu_data_write,
    input  logic [DATA_W-1:0]  register_v0,
    output logic               busy,
    output logic               done,
    output run_status_t        status,
    output logic [DATA_W-1:0]  result,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

    // Assertion is asynchronous through the sync flops; release waits two edges.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    run_state_t         state_q;
    run_state_t         state_d;
    logic               start_run;
    logic               fin;
    run_status_t        fin_status;
    logic               cap_result;
    logic               run_cnt_en;
    logic [HOLD_W-1:0]  hold_cnt;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_run  = 1'b0;
        fin        = 1'b0;
        fin_status = STAT_OK;
        cap_result = 1'b0;
        run_cnt_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RESET_HOLD;
                    start_run = 1'b1;
                end
            end
            ST_RESET_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (cpu_active) begin
                    state_d = ST_RUN;
                end else begin
                    state_d    = ST_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_NO_ACTIVE;
                end
            end
            ST_RUN: begin
`ifdef RUN_CTRL_CONFLICT_CHECK_EN
                if (cpu_data_read && cpu_data_write) begin
                    state_d    = ST_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_CONFLICT;
                end else
`endif
                if (!cpu_active) begin
                    state_d    = ST_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_OK;
                    cap_result = 1'b1;
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_d    = ST_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_TIMEOUT;
                end else begin
                    run_cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifndef RUN_CTRL_CONFLICT_CHECK_EN
    logic unused_rw;
    assign unused_rw = cpu_data_read ^ cpu_data_write;
`endif

    // Control outputs are a pure decode of the state register.
    always_comb begin
        cpu_reset      = 1'b0;
        cpu_clk_enable = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_RESET_HOLD: begin
                cpu_reset = 1'b1;
                busy      = 1'b1;
            end
            ST_ARM, ST_RUN: begin
                cpu_clk_enable = 1'b1;
                busy           = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            status <= STAT_OK;
            result <= '0;
        end else if (start_run) begin
            status <= STAT_OK;
            result <= '0;
        end else begin
            if (fin) begin
                status <= fin_status;
            end
            if (cap_result) begin
                result <= register_v0;
            end
        end
    end

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n_int),
        .clr   (state_q != ST_RESET_HOLD),
        .en    (1'b1),
        .cnt   (hold_cnt)
    );

    sat_counter #(.W(CYCLE_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n_int),
        .clr   (start_run),
        .en    (run_cnt_en),
        .cnt   (cycle_count)
    );

endmodule
